variable_precision_divider: RTL and testbench
=============================================

VARIABLE_PRECISION_DIVIDER -- requirements
Module: variable_precision_divider

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all state changes occur only on the rising edge of clk.
REQ-002 Ports, in this order:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request to begin a division.
- A  in  32  dividend magnitude.
- B  in  32  divisor magnitude.
- SA  in  1  dividend sign.
- SB  in  1  divisor sign.
- prec1, prec0  in  1 each  lane mode: 00 = 1x32; 01 = 2x16; 10 = 4x8; 11 = 4x8.
- busy  out  1  division in progress.
- done  out  1  one-cycle result-valid pulse.
- Q  out  32  quotient magnitudes, packed by lane.
- R  out  32  remainder magnitudes, packed by lane.
- SQ  out  1  quotient sign.
- SR  out  1  remainder sign.
- dbz  out  4  per-slice divide-by-zero flags; bit i covers slice i.

Function
REQ-003 Operands SHALL be sign-magnitude; all lanes SHALL share SA and SB.
REQ-004 Mode SHALL be captured together with the operands at start; changing prec1/prec0 mid-operation SHALL have no effect.
REQ-005 The FSM SHALL have three states: IDLE, RUN and DONE.
- IDLE -> RUN when start=1.
- RUN -> DONE after N iterations, where N = 32, 16 or 8 is the lane width.
- DONE -> IDLE, or DONE -> RUN if start=1 in that cycle.
REQ-006 Start SHALL be accepted in IDLE or DONE and ignored in RUN.
REQ-007 Each iteration SHALL perform one restoring radix-2 step in every lane in parallel.
- The borrow chain is cut at lane boundaries.
REQ-008 done SHALL be high for exactly one cycle, N+1 edges after the edge that samples start.
REQ-009 busy SHALL be high in RUN only.
REQ-010 Q, R, SQ, SR and dbz SHALL update only when done rises.
- They SHALL hold their values until the next done or reset.
REQ-011 SQ SHALL equal SA^SB, forced to 0 when Q==0.
REQ-012 SR SHALL equal SA, forced to 0 when R==0.
REQ-013 For a lane whose divisor is zero:
- quotient SHALL be all-ones of the lane width;
- remainder SHALL be the dividend;
- dbz SHALL be set on every slice the lane covers (1x32 lane -> 4'b1111).
REQ-014 A dividend smaller than the divisor SHALL give Q=0 and R=dividend for that lane.

Reset
REQ-015 On rst:
- the FSM SHALL go to IDLE;
- busy, done, SQ and SR SHALL be 0;
- Q, R and dbz SHALL be all-zero;
- the iteration counter SHALL be 0.
REQ-016 Reset SHALL override start in the same cycle.
REQ-017 Reset during RUN SHALL abort the operation with no done pulse.

Structure
REQ-018 Package vpd_pkg SHALL contain the following, and nothing block-local:
- the mode typedef (M32, M16, M8);
- the state typedef;
- localparams for lane widths 32/16/8 and for the counter width (6 bits).
REQ-019 Sub-module vpd_slice SHALL implement an 8-bit subtract/restore slice with borrow-in, borrow-out and a lane-boundary cut control.
- The top SHALL instantiate four vpd_slice instances.
REQ-020 Total RTL SHALL be 120-400 lines.

Verification
REQ-021 Mode 00, A=7, B=2, SA=SB=0 -> done 33 edges after start; Q=3, R=1, SQ=0, SR=0, dbz=0.
REQ-022 Mode 00, A=100, B=7, SA=1, SB=0 -> Q=14, R=2, SQ=1, SR=1.
REQ-023 Mode 01, A=0x0064_0009, B=0x000A_0002 -> done after 17 edges; Q=0x000A_0004, R=0x0000_0001.
REQ-024 Mode 10, A=0xFF10_0C07, B=0x0F03_0402 -> done after 9 edges; Q=0x1105_0303, R=0x0001_0001.
REQ-025 Divide by zero:
- Mode 00, A=5, B=0 -> Q=0xFFFF_FFFF, R=5, dbz=4'b1111.
- Mode 10, A=0x0909_0909, B=0x0300_0303 -> Q=0x03FF_0303, R=0x0009_0000, dbz=4'b0100.
REQ-026 Busy and reset handling:
- start pulsed mid-RUN -> ignored; the original result completes.
- rst mid-RUN -> no done; outputs zero; the next start works normally.

Source files
------------

// File: rtl/vpd_pkg.sv
// rtl/vpd_pkg.sv - shared types and constants for the variable precision divider
package vpd_pkg;

  typedef enum logic [1:0] {
    M32 = 2'd0,
    M16 = 2'd1,
    M8  = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int LANE_W32 = 32;
  localparam int LANE_W16 = 16;
  localparam int LANE_W8  = 8;
  localparam int CNT_W    = 6;

  // Both 4x8 encodings map to M8.
  function automatic mode_t decode_mode(input logic p1, input logic p0);
    mode_t m;
    if (p1)      m = M8;
    else if (p0) m = M16;
    else         m = M32;
    return m;
  endfunction

  function automatic logic [CNT_W-1:0] lane_iters(input mode_t m);
    logic [CNT_W-1:0] n;
    case (m)
      M32:     n = CNT_W'(LANE_W32);
      M16:     n = CNT_W'(LANE_W16);
      default: n = CNT_W'(LANE_W8);
    endcase
    return n;
  endfunction

endpackage

// File: rtl/vpd_slice.sv
// rtl/vpd_slice.sv - 8-bit subtract/restore slice of the divider datapath
module vpd_slice (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       bin,
  input  logic       cut,
  input  logic       keep,
  output logic [7:0] res,
  output logic       bout
);

  logic [8:0] d;
  logic       bi;

  // A cut slice is the bottom of its lane, so no borrow arrives from below.
  assign bi   = bin & ~cut;
  assign d    = {1'b0, a} - {1'b0, b} - {8'd0, bi};
  assign bout = d[8];
  assign res  = keep ? d[7:0] : a;

endmodule

// File: rtl/variable_precision_divider.sv
// rtl/variable_precision_divider.sv - sign-magnitude restoring divider, 1x32 / 2x16 / 4x8 lanes
module variable_precision_divider
  import vpd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        SA,
  input  logic        SB,
  input  logic        prec1,
  input  logic        prec0,
  output logic        busy,
  output logic        done,
  output logic [31:0] Q,
  output logic [31:0] R,
  output logic        SQ,
  output logic        SR,
  output logic [3:0]  dbz
);

  state_t             state, nstate;
  mode_t              mode_r, mode_in;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        rem, quo, dvs;
  logic               sa_r, sb_r;
  logic [3:0]         dbz_r, dbz_in;
  logic               accept;

  logic [31:0]        rem_sh;
  logic [3:0]         cut;
  logic [3:0]         ok_s;
  logic [31:0]        quo_nx;
  logic [7:0]         res0, res1, res2, res3;
  logic               bout0, bout1, bout2, bout3;

  assign mode_in = decode_mode(prec1, prec0);
  assign accept  = start && (state == IDLE || state == DONE);
  assign busy    = (state == RUN);

  always_comb begin
    dbz_in = 4'b0000;
    case (mode_in)
      M32: dbz_in = {4{B == 32'd0}};
      M16: dbz_in = {{2{B[31:16] == 16'd0}}, {2{B[15:0] == 16'd0}}};
      default: begin
        for (int i = 0; i < 4; i++) dbz_in[i] = (B[8*i +: 8] == 8'd0);
      end
    endcase
  end

  // Shift the next dividend bit into the bottom of each lane's partial remainder.
  always_comb begin
    rem_sh = {rem[30:0], quo[31]};
    cut    = 4'b0001;
    case (mode_r)
      M32: begin
        rem_sh = {rem[30:0], quo[31]};
        cut    = 4'b0001;
      end
      M16: begin
        rem_sh = {rem[30:16], quo[31], rem[14:0], quo[15]};
        cut    = 4'b0101;
      end
      default: begin
        for (int i = 0; i < 4; i++) rem_sh[8*i +: 8] = {rem[8*i +: 7], quo[8*i + 7]};
        cut = 4'b1111;
      end
    endcase
  end

  vpd_slice u_slice0 (.a(rem_sh[7:0]),   .b(dvs[7:0]),   .bin(1'b0),  .cut(cut[0]),
                      .keep(ok_s[0]), .res(res0), .bout(bout0));
  vpd_slice u_slice1 (.a(rem_sh[15:8]),  .b(dvs[15:8]),  .bin(bout0), .cut(cut[1]),
                      .keep(ok_s[1]), .res(res1), .bout(bout1));
  vpd_slice u_slice2 (.a(rem_sh[23:16]), .b(dvs[23:16]), .bin(bout1), .cut(cut[2]),
                      .keep(ok_s[2]), .res(res2), .bout(bout2));
  vpd_slice u_slice3 (.a(rem_sh[31:24]), .b(dvs[31:24]), .bin(bout2), .cut(cut[3]),
                      .keep(ok_s[3]), .res(res3), .bout(bout3));

  // A lane subtracts when the bit shifted out of its top is set or its top slice did not borrow.
  always_comb begin
    ok_s   = 4'b0000;
    quo_nx = quo;
    case (mode_r)
      M32: begin
        ok_s   = {4{rem[31] | ~bout3}};
        quo_nx = {quo[30:0], ok_s[0]};
      end
      M16: begin
        ok_s   = {{2{rem[31] | ~bout3}}, {2{rem[15] | ~bout1}}};
        quo_nx = {quo[30:16], ok_s[2], quo[14:0], ok_s[0]};
      end
      default: begin
        ok_s   = {rem[31] | ~bout3, rem[23] | ~bout2, rem[15] | ~bout1, rem[7] | ~bout0};
        for (int i = 0; i < 4; i++) quo_nx[8*i +: 8] = {quo[8*i +: 7], ok_s[i]};
      end
    endcase
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (start) nstate = RUN;
      RUN:     if (cnt == lane_iters(mode_r) - CNT_W'(1)) nstate = DONE;
      DONE:    nstate = start ? RUN : IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mode_r <= M32;
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      sa_r   <= 1'b0;
      sb_r   <= 1'b0;
      dbz_r  <= '0;
      done   <= 1'b0;
      Q      <= '0;
      R      <= '0;
      SQ     <= 1'b0;
      SR     <= 1'b0;
      dbz    <= '0;
    end else begin
      state <= nstate;
      done  <= (state == DONE);
      if (accept) begin
        mode_r <= mode_in;
        cnt    <= '0;
        rem    <= '0;
        quo    <= A;
        dvs    <= B;
        sa_r   <= SA;
        sb_r   <= SB;
        dbz_r  <= dbz_in;
      end else if (state == RUN) begin
        rem <= {res3, res2, res1, res0};
        quo <= quo_nx;
        cnt <= cnt + CNT_W'(1);
      end
      // Results publish from the finished datapath before a back-to-back capture replaces it.
      if (state == DONE) begin
        Q   <= quo;
        R   <= rem;
        SQ  <= (sa_r ^ sb_r) & (|quo);
        SR  <= sa_r & (|rem);
        dbz <= dbz_r;
      end
    end
  end

endmodule

// File: tb/tb_variable_precision_divider.sv
// tb/tb_variable_precision_divider.sv - self-checking bench for variable_precision_divider
module tb_variable_precision_divider;

  logic        clk = 1'b0;
  logic        rst, start, SA, SB, prec1, prec0;
  logic [31:0] A, B;
  logic        busy, done, SQ, SR;
  logic [31:0] Q, R;
  logic [3:0]  dbz;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic [3:0]  z;
    logic        sq;
    logic        sr;
    int          w;
    int          cyc;
  } exp_t;

  exp_t        expq[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          done_count = 0;
  logic [31:0] last_q = '0;

  variable_precision_divider dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .SA(SA), .SB(SB),
    .prec1(prec1), .prec0(prec0), .busy(busy), .done(done), .Q(Q), .R(R),
    .SQ(SQ), .SR(SR), .dbz(dbz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Lane-by-lane division with plain arithmetic.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                                 input logic sa, input logic sb);
    exp_t e;
    longint unsigned mask, av, bv, qv, rv;
    int w;
    w = (m == 2'd0) ? 32 : (m == 2'd1) ? 16 : 8;
    mask = (64'd1 << w) - 64'd1;
    e.q = '0; e.r = '0; e.z = '0; e.w = w; e.cyc = 0;
    for (int l = 0; l < 32 / w; l++) begin
      av = ({32'd0, a} >> (l * w)) & mask;
      bv = ({32'd0, b} >> (l * w)) & mask;
      if (bv == 0) begin
        qv = mask;
        rv = av;
        for (int s = l * w / 8; s < (l + 1) * w / 8; s++) e.z[s] = 1'b1;
      end else begin
        qv = av / bv;
        rv = av % bv;
      end
      e.q = e.q | 32'(qv << (l * w));
      e.r = e.r | 32'(rv << (l * w));
    end
    e.sq = (sa ^ sb) && (e.q != 0);
    e.sr = sa && (e.r != 0);
    return e;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      done_count++;
      if (expq.size() == 0) begin
        chk("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        e = expq.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("Q", Q, e.q);
        chk("R", R, e.r);
        chk("SQ", {31'd0, SQ}, {31'd0, e.sq});
        chk("SR", {31'd0, SR}, {31'd0, e.sr});
        chk("dbz", {28'd0, dbz}, {28'd0, e.z});
        last_q = e.q;
      end
    end
  end

  // Called at a negedge; start is sampled on the next posedge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sa, input logic sb,
                       input logic [1:0] m);
    exp_t e;
    A = a; B = b; SA = sa; SB = sb; prec1 = m[1]; prec0 = m[0]; start = 1'b1;
    e = model(a, b, m, sa, sb);
    e.cyc = cyc + 1 + e.w + 1;
    expq.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (expq.size() > 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (expq.size() > 0) begin
      chk("drain_timeout", expq.size(), 0);
      expq.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic sa, input logic sb,
                     input logic [1:0] m);
    issue(a, b, sa, sb, m);
    drain();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_Q"}, Q, 32'd0);
    chk({tag, "_R"}, R, 32'd0);
    chk({tag, "_sign"}, {30'd0, SQ, SR}, 32'd0);
    chk({tag, "_dbz"}, {28'd0, dbz}, 32'd0);
  endtask

  initial begin
    exp_t e;
    int dc;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; SA = 1'b0; SB = 1'b0; prec1 = 1'b0; prec0 = 1'b0;
    idle(3);
    rst = 1'b0;
    check_zero("reset");

    // Hand-computed expectations that pin the model.
    e = model(32'd7, 32'd2, 2'd0, 1'b0, 1'b0);
    chk("model_7div2", {e.q[15:0], e.r[15:0]}, {16'd3, 16'd1});
    e = model(32'd100, 32'd7, 2'd0, 1'b1, 1'b0);
    chk("model_100div7", {e.q[15:0], e.r[15:0]}, {16'd14, 16'd2});
    chk("model_100div7_sign", {30'd0, e.sq, e.sr}, 32'd3);
    e = model(32'h0064_0009, 32'h000A_0002, 2'd1, 1'b0, 1'b0);
    chk("model_m16_q", e.q, 32'h000A_0004);
    e = model(32'hFF10_0C07, 32'h0F03_0402, 2'd2, 1'b0, 1'b0);
    chk("model_m8_q", e.q, 32'h1105_0303);
    chk("model_m8_r", e.r, 32'h0001_0001);
    e = model(32'h0909_0909, 32'h0300_0303, 2'd2, 1'b0, 1'b0);
    chk("model_dbz8", {e.q[31:4], e.z}, {28'h03FF_030, 4'b0100});
    e = model(32'd5, 32'd0, 2'd0, 1'b0, 1'b0);
    chk("model_dbz32", {e.q[27:0], e.z}, {28'hFFF_FFFF, 4'b1111});

    run(32'd7, 32'd2, 1'b0, 1'b0, 2'd0);
    run(32'd100, 32'd7, 1'b1, 1'b0, 2'd0);
    run(32'h0064_0009, 32'h000A_0002, 1'b0, 1'b0, 2'd1);
    run(32'hFF10_0C07, 32'h0F03_0402, 1'b0, 1'b0, 2'd2);
    run(32'd5, 32'd0, 1'b0, 1'b0, 2'd0);
    run(32'h0909_0909, 32'h0300_0303, 1'b0, 1'b0, 2'd2);
    run(32'hFF10_0C07, 32'h0F03_0402, 1'b1, 1'b1, 2'd3);
    run(32'd100, 32'd7, 1'b0, 1'b1, 2'd0);
    run(32'd6, 32'd3, 1'b1, 1'b0, 2'd0);
    run(32'd3, 32'd9, 1'b1, 1'b0, 2'd0);
    run(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 2'd0);
    run(32'h1234_0000, 32'h0000_0007, 1'b1, 1'b1, 2'd1);

    // Outputs hold after done.
    idle(5);
    chk("hold_Q", Q, last_q);

    // Start and mode change mid-RUN are ignored.
    dc = done_count;
    issue(32'd1000, 32'd33, 1'b0, 1'b0, 2'd0);
    idle(4);
    chk("busy_run", {31'd0, busy}, 32'd1);
    A = 32'h0F0F_0F0F; B = 32'h0101_0101; prec1 = 1'b1; prec0 = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    idle(40);
    chk("single_done", done_count - dc, 1);

    // Back-to-back: start accepted in the DONE cycle.
    issue(32'h00FF_0010, 32'h0010_0003, 1'b0, 1'b0, 2'd1);
    for (int t = 0; t < 40 && busy; t++) @(negedge clk);
    issue(32'h8040_2010, 32'h0703_0201, 1'b0, 1'b1, 2'd2);
    drain();

    // Reset mid-RUN aborts with no done.
    dc = done_count;
    issue(32'd999, 32'd10, 1'b1, 1'b1, 2'd0);
    idle(10);
    rst = 1'b1;
    expq.delete();
    @(negedge clk);
    rst = 1'b0;
    check_zero("abort");
    idle(40);
    chk("abort_no_done", done_count - dc, 0);

    // Reset overrides start in the same cycle.
    rst = 1'b1; start = 1'b1; A = 32'd9; B = 32'd3; prec1 = 1'b0; prec0 = 1'b0;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_over_start_busy", {31'd0, busy}, 32'd0);
    idle(40);
    chk("rst_over_start_done", done_count - dc, 0);

    run(32'd50, 32'd6, 1'b0, 1'b0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
